// File: rtl/bsg_link_ds_mc_credit.sv
// bsg_link_ds_mc_credit
// Multi-channel downstream link receiver. Incoming flits are steered by
// channel ID into per-channel FIFOs. Each FIFO is presented to the core with
// a valid/yumi handshake. Credits go back upstream as one token toggle per
// CREDIT_DECIM dequeues.
//
// Optional build macro: BSG_LINK_DS_OVF_CHECK_EN
//   defined   -> err_o[c] is a sticky flag, set when a flit targets a full channel
//   undefined -> err_o is tied to 0 and no overflow-detect logic is built
// Overflow flits are dropped in both builds.
module bsg_link_ds_mc_credit #(
    parameter int NUM_CH       = 2,
    parameter int WIDTH        = 16,
    parameter int DEPTH        = 8,
    parameter int CREDIT_DECIM = 4
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          io_valid_i,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] io_ch_i,
    input  logic [WIDTH-1:0]                              io_data_i,
    output logic [NUM_CH-1:0]                             core_valid_o,
    output logic [NUM_CH*WIDTH-1:0]                       core_data_o,
    input  logic [NUM_CH-1:0]                             core_yumi_i,
    output logic [NUM_CH-1:0]                             token_o,
    output logic [NUM_CH-1:0]                             full_o,
    output logic [NUM_CH-1:0]                             err_o
);

    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    // A decimation of 1 still needs a one-bit counter. It sits at 0, so every
    // dequeue counts as a wrap.
    localparam int CW  = (CREDIT_DECIM > 1) ? $clog2(CREDIT_DECIM) : 1;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [PW-1:0]    r_wptr;
        logic [PW-1:0]    r_rptr;
        logic [CW-1:0]    r_cnt;
        logic             r_token;
        logic [WIDTH-1:0] r_mem [DEPTH];

        logic w_sel;
        logic w_full;
        logic w_empty;
        logic w_enq;
        logic w_deq;
        logic w_wrap;

        // An out-of-range channel ID matches no channel, so the flit is discarded.
        assign w_sel   = io_valid_i && (io_ch_i == CHW'(c));
        assign w_empty = (r_wptr == r_rptr);
        assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                         (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
        // Both qualifiers use the registered pointers. A same-cycle dequeue
        // therefore neither frees a slot for this enqueue nor consumes a flit
        // that arrives in the same cycle.
        assign w_enq   = w_sel && !w_full;
        assign w_deq   = core_yumi_i[c] && !w_empty;
        assign w_wrap  = (r_cnt == CW'(CREDIT_DECIM - 1));

        // Flit storage. It has no reset because the pointers alone define
        // which entries are valid.
        always_ff @(posedge clk) begin
            if (w_enq) begin
                r_mem[r_wptr[AW-1:0]] <= io_data_i;
            end
        end

        // Write/read pointers. The extra MSB tells full apart from empty.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_enq) r_wptr <= r_wptr + PW'(1);
                if (w_deq) r_rptr <= r_rptr + PW'(1);
            end
        end

        // Credit decimation: the token flips on the dequeue that wraps the counter.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt   <= '0;
                r_token <= 1'b0;
            end else if (w_deq) begin
                r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
                if (w_wrap) r_token <= ~r_token;
            end
        end

        assign core_valid_o[c]                = !w_empty;
        assign core_data_o[c*WIDTH +: WIDTH]  = r_mem[r_rptr[AW-1:0]];
        assign token_o[c]                     = r_token;
        assign full_o[c]                      = w_full;

`ifdef BSG_LINK_DS_OVF_CHECK_EN
        logic r_err;

        // Sticky overflow flag. Only reset clears it.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_err <= 1'b0;
            end else if (w_sel && w_full) begin
                r_err <= 1'b1;
            end
        end

        assign err_o[c] = r_err;
`else
        assign err_o[c] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_bsg_link_ds_mc_credit.sv
// Testbench for bsg_link_ds_mc_credit (NUM_CH=2, WIDTH=16, DEPTH=8, CREDIT_DECIM=4).
// The reference model keeps one data queue per channel, a running dequeue
// count per channel and a sticky overflow bit per channel.
module tb_bsg_link_ds_mc_credit;

    localparam int NUM_CH = 2;
    localparam int WIDTH  = 16;
    localparam int DEPTH  = 8;
    localparam int DECIM  = 4;

    logic                      clk;
    logic                      rst_n;
    logic                      io_valid_i;
    logic [0:0]                io_ch_i;
    logic [WIDTH-1:0]          io_data_i;
    logic [NUM_CH-1:0]         core_valid_o;
    logic [NUM_CH*WIDTH-1:0]   core_data_o;
    logic [NUM_CH-1:0]         core_yumi_i;
    logic [NUM_CH-1:0]         token_o;
    logic [NUM_CH-1:0]         full_o;
    logic [NUM_CH-1:0]         err_o;

    int n_tests;
    int n_fail;

    logic [WIDTH-1:0] m_q [NUM_CH][$];
    int               m_ndeq [NUM_CH];
    bit               m_err [NUM_CH];

    bsg_link_ds_mc_credit #(
        .NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEPTH(DEPTH), .CREDIT_DECIM(DECIM)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .io_valid_i(io_valid_i), .io_ch_i(io_ch_i), .io_data_i(io_data_i),
        .core_valid_o(core_valid_o), .core_data_o(core_data_o),
        .core_yumi_i(core_yumi_i), .token_o(token_o),
        .full_o(full_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < NUM_CH; c++) begin
            m_q[c].delete();
            m_ndeq[c] = 0;
            m_err[c]  = 1'b0;
        end
    endtask

    // Compare every DUT output with the model. Head data is checked only
    // where the model says the channel holds something.
    task automatic check_outputs(input string tag);
        logic [NUM_CH-1:0] e_valid, e_full, e_tok, e_err;
        for (int c = 0; c < NUM_CH; c++) begin
            e_valid[c] = (m_q[c].size() != 0);
            e_full[c]  = (m_q[c].size() == DEPTH);
            e_tok[c]   = ((m_ndeq[c] / DECIM) % 2) == 1;
`ifdef BSG_LINK_DS_OVF_CHECK_EN
            e_err[c]   = m_err[c];
`else
            e_err[c]   = 1'b0;
`endif
        end
        chk({tag, "_valid"}, 32'(core_valid_o), 32'(e_valid));
        chk({tag, "_full"},  32'(full_o),       32'(e_full));
        chk({tag, "_token"}, 32'(token_o),      32'(e_tok));
        chk({tag, "_err"},   32'(err_o),        32'(e_err));
        for (int c = 0; c < NUM_CH; c++) begin
            if (m_q[c].size() != 0)
                chk($sformatf("%s_data%0d", tag, c),
                    32'(core_data_o[c*WIDTH +: WIDTH]), 32'(m_q[c][0]));
        end
    endtask

    // Drive one cycle starting at a negedge, update the model from the
    // pre-edge occupancy, then check the outputs at the following negedge.
    task automatic step(input string tag, input logic vi, input logic ch,
                        input logic [WIDTH-1:0] d, input logic [NUM_CH-1:0] y);
        bit pre_full [NUM_CH];
        bit pre_empty [NUM_CH];
        io_valid_i  = vi;
        io_ch_i     = ch;
        io_data_i   = d;
        core_yumi_i = y;
        for (int c = 0; c < NUM_CH; c++) begin
            pre_full[c]  = (m_q[c].size() == DEPTH);
            pre_empty[c] = (m_q[c].size() == 0);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (y[c] && !pre_empty[c]) begin
                void'(m_q[c].pop_front());
                m_ndeq[c]++;
            end
        end
        if (vi) begin
            if (pre_full[ch]) m_err[ch] = 1'b1;
            else              m_q[ch].push_back(d);
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic drain();
        for (int k = 0; k < 2 * DEPTH + 2; k++) begin
            if (m_q[0].size() == 0 && m_q[1].size() == 0) break;
            step("drain", 1'b0, 1'b0, '0, 2'b11);
        end
    endtask

    initial begin
        int sent;
        int m;
        logic [WIDTH-1:0] vals [DEPTH];
        n_tests = 0;
        n_fail  = 0;
        model_clear();

        // Reset held while a flit is being offered.
        rst_n       = 1'b0;
        io_valid_i  = 1'b1;
        io_ch_i     = 1'b0;
        io_data_i   = 16'hBEEF;
        core_yumi_i = 2'b00;
        repeat (3) @(negedge clk);
        check_outputs("rst_hold");
        rst_n = 1'b1;
        step("rst_first", 1'b1, 1'b0, 16'h1234, 2'b00);
        chk("rst_first_valid01", 32'(core_valid_o), 32'h1);
        chk("rst_first_data", 32'(core_data_o[15:0]), 32'h1234);
        drain();

        // Credit: fill ch1, then dequeue back-to-back.
        for (int i = 0; i < DEPTH; i++) begin
            vals[i] = 16'(32'hA100 + i);
            step("cred_enq", 1'b1, 1'b1, vals[i], 2'b00);
        end
        chk("cred_full1", 32'(full_o[1]), 32'h1);
        for (int i = 0; i < DEPTH; i++) begin
            chk("cred_order", 32'(core_data_o[WIDTH +: WIDTH]), 32'(vals[i]));
            step("cred_deq", 1'b0, 1'b0, '0, 2'b10);
            if (i == 3) chk("cred_tok4", 32'(token_o[1]), 32'h1);
            if (i == 7) chk("cred_tok8", 32'(token_o[1]), 32'h0);
        end

        // Overflow: a ninth flit to a full channel is dropped.
        for (int i = 0; i < DEPTH; i++) begin
            vals[i] = 16'($urandom);
            step("ovf_enq", 1'b1, 1'b0, vals[i], 2'b00);
        end
        step("ovf_9th", 1'b1, 1'b0, 16'hDEAD, 2'b00);
        for (int i = 0; i < DEPTH; i++) begin
            chk("ovf_drain", 32'(core_data_o[15:0]), 32'(vals[i]));
            step("ovf_deq", 1'b0, 1'b0, '0, 2'b01);
        end
        chk("ovf_empty", 32'(core_valid_o[0]), 32'h0);

        // Simultaneous enqueue and dequeue on ch0 with 3 flits held.
        for (int i = 0; i < 3; i++) step("sim_pre", 1'b1, 1'b0, 16'($urandom), 2'b00);
        for (int i = 0; i < 10; i++) step("sim", 1'b1, 1'b0, 16'($urandom), 2'b01);
        chk("sim_occ", 32'(m_q[0].size()), 32'd3);
        drain();

        // Interleave ch0/ch1 with random yumi and no overflow attempts.
        sent = 0;
        for (int k = 0; k < 400 && sent < 40; k++) begin
            logic ch;
            logic vi;
            ch = 1'(sent % 2);
            vi = (m_q[ch].size() < DEPTH);
            step("ilv", vi, ch, 16'($urandom), 2'($urandom));
            if (vi) sent++;
        end
        chk("ilv_sent", 32'(sent), 32'd40);
        drain();

        // Mid-operation reset with 5 flits buffered and a credit count of 2 on ch0.
        m = (2 - (m_ndeq[0] % DECIM) + DECIM) % DECIM;
        for (int i = 0; i < 5 + m; i++) step("mrst_fill", 1'b1, 1'b0, 16'($urandom), 2'b00);
        for (int i = 0; i < m; i++) step("mrst_deq", 1'b0, 1'b0, '0, 2'b01);
        chk("mrst_occ", 32'(m_q[0].size()), 32'd5);
        io_valid_i  = 1'b0;
        core_yumi_i = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        check_outputs("mrst_now");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DECIM; i++) step("mrst_refill", 1'b1, 1'b0, 16'($urandom), 2'b00);
        for (int i = 0; i < DECIM; i++) step("mrst_drain", 1'b0, 1'b0, '0, 2'b01);
        chk("mrst_one_toggle", 32'(token_o[0]), 32'h1);

        // Fully random traffic, overflow attempts included.
        for (int k = 0; k < 300; k++)
            step("rnd", 1'($urandom), 1'($urandom), 16'($urandom), 2'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
